// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC3 post-decimation sample buffer.
package cic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN
    } buf_state_t;

    // A third-order CIC grows the 1-bit input by 3*log2(R) bits.
    function automatic int cic_numbits(input int decimation_factor);
        return 3 * $clog2(decimation_factor) + 1;
    endfunction

    // Unsigned CIC output that corresponds to a zero-valued bipolar sample.
    function automatic logic [63:0] cic_midscale(input int numbits);
        return 64'd1 << (numbits - 2);
    endfunction

endpackage

// File: rtl/cic_sample_fifo.sv
// Synchronous show-ahead FIFO: the head word is presented whenever the FIFO is non-empty.
module cic_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
    assign empty   = (level == '0);
    assign full    = (level == LEVEL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LEVEL_W'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LEVEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cic3_sample_buffer.sv
// Captures decimated CIC3 words, drops the settling samples, re-centres/saturates/truncates
// them and queues the results for a valid/ready consumer.
module cic3_sample_buffer
    import cic_pkg::*;
#(
    parameter int DECIMATION_FACTOR = 256,
    parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
    parameter int NUMBITS           = cic_numbits(2 ** CLOCK_WIDTH),
    parameter int OUT_WIDTH         = 16,
    parameter int FIFO_DEPTH        = 8,
    parameter int SETTLE_SAMPLES    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUMBITS-1:0]            cic_out,
    input  logic                          cic_strobe,
    output logic [OUT_WIDTH-1:0]          sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          saturated,
    input  logic                          clear_flags
);

    localparam int CNT_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
    localparam logic [NUMBITS-1:0] MIDSCALE = NUMBITS'(cic_midscale(NUMBITS));

    buf_state_t           state;
    buf_state_t           state_next;
    logic [CNT_W-1:0]     settle_cnt;
    logic                 capture;
    logic                 settle_strobe;

    logic                 cap_valid;
    logic [NUMBITS-1:0]   cap_data;
    logic [NUMBITS-1:0]   centred;
    logic                 clamp_hi;
    logic                 clamp_lo;
    logic [OUT_WIDTH-1:0] trunc;
    logic                 s2_valid;
    logic [OUT_WIDTH-1:0] s2_data;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 sat_set;
    logic                 ovf_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
                SETTLE:  if (cic_strobe && settle_cnt <= CNT_W'(1)) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        capture       = 1'b0;
        settle_strobe = 1'b0;
        case (state)
            SETTLE:  settle_strobe = enable && cic_strobe;
            RUN:     capture       = enable && cic_strobe;
            default: ;
        endcase
    end

    // The discard count is reloaded for as long as the block sits idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= CNT_W'(SETTLE_SAMPLES);
        end else if (state == IDLE) begin
            settle_cnt <= CNT_W'(SETTLE_SAMPLES);
        end else if (settle_strobe && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else if (!enable) begin
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= capture;
            if (capture) begin
                cap_data <= cic_out;
            end
        end
    end

    // Out of range exactly when the two top bits of the re-centred word disagree.
    assign centred  = cap_data - MIDSCALE;
    assign clamp_hi = !centred[NUMBITS-1] && centred[NUMBITS-2];
    assign clamp_lo = centred[NUMBITS-1] && !centred[NUMBITS-2];

    always_comb begin
        trunc = centred[NUMBITS-2 -: OUT_WIDTH];
        if (clamp_hi) begin
            trunc = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (clamp_lo) begin
            trunc = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    if (NUMBITS - 1 > OUT_WIDTH) begin : g_discard
        logic unused_lsbs;
        assign unused_lsbs = ^centred[NUMBITS-2-OUT_WIDTH:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (!enable) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= cap_valid;
            if (cap_valid) begin
                s2_data <= trunc;
            end
        end
    end

    assign pop     = sample_valid && sample_ready;
    assign sat_set = enable && cap_valid && (clamp_hi || clamp_lo);
    assign ovf_set = enable && s2_valid && fifo_full && !pop;

    // A set event on the same edge as clear_flags takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            saturated <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (sat_set) begin
                saturated <= 1'b1;
            end else if (clear_flags) begin
                saturated <= 1'b0;
            end
        end
    end

    cic_sample_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (!enable),
        .push      (s2_valid && enable),
        .push_data (s2_data),
        .pop       (sample_ready),
        .head      (sample_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    assign sample_valid = !fifo_empty;

endmodule

// File: doc/cic3_sample_buffer.md
# cic3_sample_buffer

Post-decimation stage directly downstream of the CIC3 decimator. It captures each decimated CIC output word on a strobe in the fast `clk` domain. It discards the first samples after enable, while the filter settles. It re-centres each sample to signed bipolar, saturates it and truncates it to `OUT_WIDTH`. It buffers the result in a small FIFO that the readout logic drains through a valid/ready handshake.

## Interface
- `DECIMATION_FACTOR`, 256: CIC decimation ratio (power of 2).
- `CLOCK_WIDTH`, `$clog2(DECIMATION_FACTOR)`: decimation counter width.
- `NUMBITS`, `3*CLOCK_WIDTH+1`: CIC output width (25 by default).
- `OUT_WIDTH`, 16: delivered sample width; must be ≤ `NUMBITS-1`.
- `FIFO_DEPTH`, 8: FIFO entries; power of 2, ≥ 2.
- `SETTLE_SAMPLES`, 3: strobes discarded after enable (filter order).
- `clk` input 1: modulator clock, the only clock. All logic is on its posedge.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: level; low means idle and flush.
- `cic_out` input `NUMBITS`: unsigned CIC output word; stable in the cycle `cic_strobe` is high.
- `cic_strobe` input 1: one-cycle pulse per decimated sample. Consecutive pulses are ≥ 3 cycles apart.
- `sample_data` output `OUT_WIDTH`: signed two's-complement FIFO head.
- `sample_valid` output 1: FIFO non-empty.
- `sample_ready` input 1: consumer accepts the head this cycle.
- `fifo_level` output `$clog2(FIFO_DEPTH)+1`: occupancy, 0..`FIFO_DEPTH`.
- `overflow` output 1: sticky; a sample was dropped because the FIFO was full.
- `saturated` output 1: sticky; a sample was clamped.
- `clear_flags` input 1: synchronous clear of `overflow` and `saturated`.

## Operation
- States `IDLE`, `SETTLE`, `RUN`. Reset puts the block in `IDLE`.
- `IDLE` → `SETTLE` when `enable` is high. The discard counter loads `SETTLE_SAMPLES`.
- `SETTLE`: each strobe decrements the counter and is dropped. Go to `RUN` after the strobe that brings the counter to 0. With `SETTLE_SAMPLES`=0, go directly to `RUN`.
- Any state → `IDLE` when `enable` is low.
  - The FIFO is flushed on that edge: level 0, pointers 0.
  - An in-flight pipeline sample is discarded.
  - Sticky flags are kept.
- Stage 1: the capture register loads `cic_out` on a strobe in `RUN`.
- Stage 2: `c = cic_out - 2^(NUMBITS-2)`, computed at `NUMBITS` width and treated as signed.
  - Clamp `c` to [-2^(NUMBITS-2), 2^(NUMBITS-2)-1]. Set `saturated` if the clamp was active.
  - `sample_data` entry = `c[NUMBITS-2 -: OUT_WIDTH]` (floor truncation).
- Write and pop rules:
  - Push the stage-2 result. Pop when `sample_valid && sample_ready`.
  - Full with a push and no pop: the new sample is dropped and `overflow` is set.
  - Full with a push and a pop in the same cycle: both happen and the level is unchanged.
  - Empty with a push: the pop is ignored, since valid is low.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `clear_flags` in the same cycle as a new set event: the set wins.

## Timing
- Reset values: `sample_data` 0, `sample_valid` 0, `fifo_level` 0, `overflow` 0, `saturated` 0, state `IDLE`.
- Latency: strobe sampled at edge T → entry written at edge T+2 → `sample_valid`/`sample_data` visible after edge T+2.
- The FIFO is show-ahead: `sample_data` is the head whenever `sample_valid` is high. It does not change unless a pop occurs. The next head appears the cycle after a pop.
- `sample_ready` may be held high permanently. There is no combinational path from `sample_ready` to `sample_valid`.
- A strobe in the same cycle as the `SETTLE`→`RUN` edge is dropped. The first kept strobe is the next one.
- Reset asserted mid-operation clears everything asynchronously. Operation restarts in `IDLE` and settles again.

## Structure
- Package `cic_pkg` holds:
  - the state enum `buf_state_t` (`IDLE`, `SETTLE`, `RUN`);
  - a function for `NUMBITS` from `DECIMATION_FACTOR`;
  - the midscale constant helper.
- Sub-module `cic_sample_fifo`: a parameterised synchronous show-ahead FIFO with push, pop, flush, level and full/empty outputs. The top level holds the FSM, the settle counter, the pipeline and the flags.

## Test plan
- Reset, then enable with strobes every 256 cycles at `cic_out`=0x800000 → first 3 strobes are dropped; the 4th yields `sample_data`=0x0000 two cycles after its strobe, with `fifo_level`=1.
- Kept strobes with `cic_out` = 0x1000000, 0x000000, 0x900000 → data 0x7FFF (`saturated`=1), 0x8000, 0x1000 in order.
- `sample_ready`=0 for 10 kept strobes with `FIFO_DEPTH`=8 → level 8, `overflow`=1, the 8 oldest are retained. Then `clear_flags` → `overflow`=0.
- FIFO full, with `sample_ready`=1 in the same cycle as a push → level stays 8, no overflow, order preserved.
- Drop `enable` with 5 entries queued and a strobe one cycle earlier → next cycle level 0, valid 0. Re-enable → 3 strobes are discarded again.
- Assert `reset` mid-burst → all outputs return to their reset values immediately. After release, the block behaves as in the first scenario.
